// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with execute/load write ports, same-cycle bypass,
// optional hardwired zero register and a per-register outstanding-load scoreboard.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] Bus_A,
  output logic [DATA_W-1:0] Bus_B,
  output logic              busy_A,
  output logic              busy_B,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] Bus_W,
  input  logic              ld_write,
  input  logic [ADDR_W-1:0] ld_RW,
  input  logic [DATA_W-1:0] ld_Bus_W,
  input  logic              set_busy,
  input  logic [ADDR_W-1:0] busy_addr
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy, set_mask, clr_mask;
  logic              w_ok, ld_ok;
  always_comb begin
    w_ok     = reg_write && !(ZERO_REG && RW == '0);
    ld_ok    = ld_write && !(ZERO_REG && ld_RW == '0);
    set_mask = (set_busy && !(ZERO_REG && busy_addr == '0)) ? DEPTH'(1) << busy_addr : '0;
    clr_mask = ld_write ? DEPTH'(1) << ld_RW : '0;
  end
  // execute write is issued last so it overrides a load return to the same register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (ld_ok) regs[ld_RW] <= ld_Bus_W;
      if (w_ok) regs[RW] <= Bus_W;
      busy <= (busy & ~clr_mask) | set_mask;
    end
  always_comb begin
    Bus_A  = (ZERO_REG && RA == '0) ? '0 :
             (rst_n && reg_write && RW == RA) ? Bus_W :
             (rst_n && ld_write && ld_RW == RA) ? ld_Bus_W : regs[RA];
    Bus_B  = (ZERO_REG && RB == '0) ? '0 :
             (rst_n && reg_write && RW == RB) ? Bus_W :
             (rst_n && ld_write && ld_RW == RB) ? ld_Bus_W : regs[RB];
    busy_A = rst_n && busy[RA] && !(ld_write && ld_RW == RA);
    busy_B = rst_n && busy[RB] && !(ld_write && ld_RW == RB);
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: default (32x32, zero reg) and small (8x16, no zero reg) instances
// driven by shared stimulus and checked against an array-based model every cycle.
module tb_reg_file_sb;
  logic        clk = 0, rst_n = 1, run = 0;
  logic [4:0]  ra = 0, rb = 0, rw = 0, lrw = 0, baddr = 0;
  logic [31:0] bw = 0, lbw = 0;
  logic        we = 0, le = 0, sb = 0;
  logic [31:0] bus_a0, bus_b0;
  logic [15:0] bus_a1, bus_b1;
  logic        busy_a0, busy_b0, busy_a1, busy_b1;
  int          checks = 0, failures = 0;
  logic [31:0] mr [2][32];
  bit          mb [2][32];

  always #5 clk = ~clk;

  reg_file_sb u0 (
    .clk(clk), .rst_n(rst_n), .RA(ra), .RB(rb), .Bus_A(bus_a0), .Bus_B(bus_b0),
    .busy_A(busy_a0), .busy_B(busy_b0), .reg_write(we), .RW(rw), .Bus_W(bw),
    .ld_write(le), .ld_RW(lrw), .ld_Bus_W(lbw), .set_busy(sb), .busy_addr(baddr)
  );
  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .RA(ra[2:0]), .RB(rb[2:0]), .Bus_A(bus_a1), .Bus_B(bus_b1),
    .busy_A(busy_a1), .busy_B(busy_b1), .reg_write(we), .RW(rw[2:0]), .Bus_W(bw[15:0]),
    .ld_write(le), .ld_RW(lrw[2:0]), .ld_Bus_W(lbw[15:0]), .set_busy(sb), .busy_addr(baddr[2:0])
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // instance k: k=0 has 32 regs, 32-bit data, r0 hardwired; k=1 has 8 regs, 16-bit data
  function automatic int amask(int k);
    return k == 1 ? 7 : 31;
  endfunction
  function automatic logic [31:0] dmask(int k);
    return k == 1 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] e_bus(int k, logic [4:0] a);
    int x = int'(a) & amask(k);
    if (k == 0 && x == 0) return 0;
    if (!rst_n) return mr[k][x];
    if (we && (int'(rw) & amask(k)) == x) return bw & dmask(k);
    if (le && (int'(lrw) & amask(k)) == x) return lbw & dmask(k);
    return mr[k][x];
  endfunction

  function automatic logic [31:0] e_busy(int k, logic [4:0] a);
    int x = int'(a) & amask(k);
    if (!rst_n || (k == 0 && x == 0)) return 0;
    return {31'b0, mb[k][x] && !(le && (int'(lrw) & amask(k)) == x)};
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 32; i++) begin
          mr[k][i] <= 0;
          mb[k][i] <= 0;
        end
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic int lx = int'(lrw) & amask(k);
        automatic int wx = int'(rw) & amask(k);
        automatic int bx = int'(baddr) & amask(k);
        if (le && !(k == 0 && lx == 0)) mr[k][lx] <= lbw & dmask(k);
        if (we && !(k == 0 && wx == 0)) mr[k][wx] <= bw & dmask(k);
        if (le) mb[k][lx] <= 0;
        if (sb && !(k == 0 && bx == 0)) mb[k][bx] <= 1;
      end
    end

  always @(negedge clk)
    if (run) begin
      chk("bus_a0", bus_a0, e_bus(0, ra));
      chk("bus_b0", bus_b0, e_bus(0, rb));
      chk("busy_a0", {31'b0, busy_a0}, e_busy(0, ra));
      chk("busy_b0", {31'b0, busy_b0}, e_busy(0, rb));
      chk("bus_a1", {16'b0, bus_a1}, e_bus(1, ra));
      chk("bus_b1", {16'b0, bus_b1}, e_bus(1, rb));
      chk("busy_a1", {31'b0, busy_a1}, e_busy(1, ra));
      chk("busy_b1", {31'b0, busy_b1}, e_busy(1, rb));
    end

  task automatic step();
    @(posedge clk);
    #1;
    {we, le, sb} = 3'b000;
  endtask

  function automatic logic [4:0] rnd_a();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    #1 rst_n = 0;
    run = 1;
    #2;
    chk("rst_bus_a", bus_a0, 0);
    chk("rst_busy_a", {31'b0, busy_a0}, 0);
    #9 rst_n = 1;
    step(); we = 1; rw = 7; bw = 32'h1234_5678; ra = 7; rb = 3; #1;
    chk("byp_a", bus_a0, 32'h1234_5678);
    chk("byp_b", bus_b0, 0);
    chk("byp_a16", {16'b0, bus_a1}, 32'h5678);
    step(); #1;
    chk("wr_a", bus_a0, 32'h1234_5678);
    step(); we = 1; rw = 7; bw = 32'h0000_BEEF;
    step(); #1;
    chk("p16_r7", {16'b0, bus_a1}, 32'hBEEF);
    step(); we = 1; rw = 0; bw = 32'hFFFF_FFFF; sb = 1; baddr = 0; ra = 0; #1;
    chk("zero_byp", bus_a0, 0);
    chk("zero_busy", {31'b0, busy_a0}, 0);
    chk("nozero_byp", {16'b0, bus_a1}, 32'hFFFF);
    step(); #1;
    chk("zero_after", bus_a0, 0);
    chk("zero_busy_after", {31'b0, busy_a0}, 0);
    chk("nozero_r0", {16'b0, bus_a1}, 32'hFFFF);
    chk("nozero_busy", {31'b0, busy_a1}, 1);
    step(); we = 1; rw = 9; bw = 32'hAA; le = 1; lrw = 9; lbw = 32'hBB; ra = 9; #1;
    chk("coll_byp", bus_a0, 32'hAA);
    step(); #1;
    chk("coll_after", bus_a0, 32'hAA);
    step(); sb = 1; baddr = 4; ra = 4; #1;
    chk("sb_pre", {31'b0, busy_a0}, 0);
    step(); #1;
    chk("sb_set", {31'b0, busy_a0}, 1);
    step(); step();
    step(); le = 1; lrw = 4; lbw = 32'h55; #1;
    chk("sb_ret_busy", {31'b0, busy_a0}, 0);
    chk("sb_ret_bus", bus_a0, 32'h55);
    step(); #1;
    chk("sb_clr", {31'b0, busy_a0}, 0);
    step(); sb = 1; baddr = 6; ra = 6;
    step(); le = 1; lrw = 6; lbw = 32'h66; sb = 1; baddr = 6; #1;
    chk("race_busy_now", {31'b0, busy_a0}, 0);
    step(); #1;
    chk("race_busy", {31'b0, busy_a0}, 1);
    chk("race_data", bus_a0, 32'h66);
    step(); we = 1; rw = 5; bw = 32'hDEAD_BEEF; ra = 5;
    step(); #1;
    chk("pre_rst", bus_a0, 32'hDEAD_BEEF);
    #1 rst_n = 0;
    #1 chk("rst_async", bus_a0, 0);
    step(); rst_n = 1;
    for (int i = 0; i < 32; i++) begin
      step(); ra = 5'(i); rb = 5'(31 - i); #1;
      chk("post_rst_busy", {31'b0, busy_a0}, 0);
    end
    for (int n = 0; n < 2000; n++) begin
      step();
      rst_n = ($urandom_range(0, 299) != 0);
      ra = rnd_a(); rb = rnd_a(); rw = rnd_a(); lrw = rnd_a(); baddr = rnd_a();
      bw = $urandom; lbw = $urandom;
      we = ($urandom_range(0, 1) == 1);
      le = ($urandom_range(0, 2) == 0);
      sb = ($urandom_range(0, 2) == 0);
    end
    step();
    rst_n = 1;
    @(negedge clk);
    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the team's 32x32 register file: two asynchronous read ports, two synchronous write ports (execute write-back and load return), same-cycle write-to-read bypass, optional hardwired zero register, and a per-register busy scoreboard that tracks outstanding loads. It sits between decode (reads, busy checks, load issue) and the write-back stage of the CPU datapath.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy; 0 = register 0 is ordinary
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- RA  in  ADDR_W  read address, port A
- RB  in  ADDR_W  read address, port B
- Bus_A  out  DATA_W  read data, port A (combinational)
- Bus_B  out  DATA_W  read data, port B (combinational)
- busy_A  out  1  register RA has an outstanding load
- busy_B  out  1  register RB has an outstanding load
- reg_write  in  1  execute write enable
- RW  in  ADDR_W  execute write address
- Bus_W  in  DATA_W  execute write data
- ld_write  in  1  load-return write enable
- ld_RW  in  ADDR_W  load-return write address
- ld_Bus_W  in  DATA_W  load-return write data
- set_busy  in  1  load issued: mark busy_addr busy
- busy_addr  in  ADDR_W  destination of issued load

## Operation
- Storage: DEPTH x DATA_W registers plus DEPTH-bit busy vector.
- Writes on rising clk: reg_write writes Bus_W to RW; ld_write writes ld_Bus_W to ld_RW.
- Both ports same address same cycle: execute port wins; load data discarded.
- Writes to register 0 dropped when ZERO_REG=1.
- Busy update per edge, per address i: set if set_busy && busy_addr==i; else clear if ld_write && ld_RW==i; else hold. Set beats clear on the same address (new load issued as old one returns).
- Execute write does not clear busy.
- ZERO_REG=1: busy[0] always 0, set_busy to 0 ignored.
- Read path per port (A shown; B identical with RB): if ZERO_REG && RA==0 -> 0; else if reg_write && RW==RA -> Bus_W; else if ld_write && ld_RW==RA -> ld_Bus_W; else stored value.
- busy_A = busy[RA] && !(ld_write && ld_RW==RA) (returning load visible same cycle); 0 for register 0 when ZERO_REG=1.
- While rst_n low: bypass suppressed, Bus_A/Bus_B read stored values (all 0), busy outputs 0, all write/set inputs ignored.

## Timing
- Reset (async assert, any time): all registers 0, busy vector 0; Bus_A=Bus_B=0, busy_A=busy_B=0 immediately, no clock needed.
- Reset deassert: first rising edge with rst_n high performs writes; no startup bubble.
- Read latency 0 cycles (combinational from RA/RB and write inputs).
- Write latency: value in storage after the edge; visible on same-cycle reads via bypass before the edge.
- Busy set at edge N: busy_X high from after edge N until the cycle a matching ld_write is presented (low combinationally that cycle), cleared in storage at that edge.
- Reset mid-operation: pending writes and busy bits lost; no partial updates.
- No handshake back-pressure; all inputs accepted every cycle.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst_n low mid-cycle -> Bus_A (RA=5) goes 0 asynchronously; after release r5 reads 0, all busy 0.
- Write/read/bypass: reg_write RW=7 Bus_W=0x12345678 with RA=7 same cycle -> Bus_A=0x12345678 before edge; after edge reg_write=0, still 0x12345678; RB=3 reads 0.
- Zero register (ZERO_REG=1): reg_write RW=0 Bus_W=0xFFFFFFFF, set_busy busy_addr=0 -> Bus_A(RA=0)=0, busy_A=0 before and after edge; with ZERO_REG=0 r0 reads 0xFFFFFFFF.
- Dual-write collision: reg_write RW=9 Bus_W=0xAA and ld_write ld_RW=9 ld_Bus_W=0xBB same cycle -> Bus_A(RA=9)=0xAA before and after edge.
- Scoreboard: set_busy busy_addr=4 -> busy_A(RA=4)=1 next cycles; 3 cycles later ld_write ld_RW=4 ld_Bus_W=0x55 -> busy_A=0 and Bus_A=0x55 that cycle; stays 0 after edge.
- Set/clear race: r6 busy; same cycle ld_write ld_RW=6 and set_busy busy_addr=6 -> r6 updated with load data, busy[6]=1 after edge; parametric run DATA_W=16 ADDR_W=3 repeats write/read to r7 with 0xBEEF.
